// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: digit count, active-low hex glyph table and
// a reverse lookup from a segment pattern to its nibble.
package seven_seg_pkg;

    localparam int DIGITS = 4;

    // Active-low gfedcba patterns for 0..F, shared with the display encoder.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic       hit;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [6:0] seg);
        seg_dec_t res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                res.hit    = 1'b1;
                res.nibble = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Registers a bus once and strobes accept_o on the single cycle the registered
// value has been unchanged for STABLE_CYCLES consecutive clocks.
module seg_stable_filter #(
    parameter int WIDTH         = 12,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             accept_o
);

    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    count_q, count_d;
    logic             changed;

    // Comparing the incoming word with data_q tells whether data_q changes at this edge.
    assign changed = (data_i != data_q);

    always_comb begin
        if (changed) begin
            count_d = '0;
        end else if (count_q == CNT_MAX) begin
            count_d = count_q;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_i;
            count_q <= count_d;
        end
    end

    assign data_o   = data_q;
    assign accept_o = !changed && (count_q == CNT_MAX - 1'b1);

endmodule

// File: rtl/seven_segment_capture.sv
// Reconstructs digits, decimal points and frame boundaries from multiplexed
// active-low anode/segment lines, and flags protocol faults.
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_BITS  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     anode,
    input  logic [7:0]            segment,
    output logic [4*DIGITS-1:0]   data_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_point,
    output logic [DIGITS-1:0]     digit_error,
    output logic                  frame_done,
    output logic                  multi_anode,
    output logic                  anode_stuck
);

    logic [DIGITS-1:0]       anode_q;
    logic [7:0]              segment_q;
    logic                    accept;
    seg_dec_t                dec;

    logic [4*DIGITS-1:0]     data_q, data_d;
    logic [DIGITS-1:0]       valid_q, valid_d;
    logic [DIGITS-1:0]       point_q, point_d;
    logic [DIGITS-1:0]       error_q, error_d;
    logic [DIGITS-1:0]       seen_q, seen_d;
    logic                    frame_done_q, frame_done_d;
    logic                    multi_q, multi_d;
    logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;

    logic                    one_low;
    logic [1:0]              idx;
    logic [DIGITS-1:0]       sel;

    seg_stable_filter #(
        .WIDTH         (DIGITS + 8),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .data_i   ({anode, segment}),
        .data_o   ({anode_q, segment_q}),
        .accept_o (accept)
    );

    assign dec = seg_decode(segment_q[6:0]);
    assign sel = ~anode_q;

    always_comb begin
        one_low = 1'b1;
        idx     = 2'd0;
        case (anode_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        point_d      = point_q;
        error_d      = error_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        multi_d      = multi_q;

        if (accept && one_low) begin
            if ((seen_q & sel) != '0) begin
                // Repeat index closes the frame; digits not refreshed in it go blank.
                frame_done_d = 1'b1;
                valid_d      = valid_q & seen_q;
                error_d      = error_q & seen_q;
                seen_d       = sel;
            end else begin
                seen_d = seen_q | sel;
            end
            if (dec.hit) begin
                data_d[4*idx +: 4] = dec.nibble;
                valid_d[idx]       = 1'b1;
                error_d[idx]       = 1'b0;
            end else begin
                valid_d[idx] = 1'b0;
                error_d[idx] = 1'b1;
            end
            point_d[idx] = ~segment_q[7];
        end else if (accept && anode_q != '1) begin
            multi_d = 1'b1;
        end

        if (anode != anode_q) begin
            timeout_d = '0;
        end else if (timeout_q == '1) begin
            timeout_d = timeout_q;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= '0;
            valid_q      <= '0;
            point_q      <= '0;
            error_q      <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            multi_q      <= 1'b0;
            timeout_q    <= '0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            point_q      <= point_d;
            error_q      <= error_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            multi_q      <= multi_d;
            timeout_q    <= timeout_d;
        end
    end

    assign data_out    = data_q;
    assign digit_valid = valid_q;
    assign digit_point = point_q;
    assign digit_error = error_q;
    assign frame_done  = frame_done_q;
    assign multi_anode = multi_q;
    assign anode_stuck = (timeout_q == '1);

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: emulated display scans, bad patterns,
// glitches, multi-anode, stuck anode and mid-frame reset.
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic [15:0] data_out;
    logic [3:0]  digit_valid, digit_point, digit_error;
    logic        frame_done, multi_anode, anode_stuck;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_count = 0;
    int fd_last = 0;
    int fd_prev = 0;

    seven_segment_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_BITS  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anode       (anode),
        .segment     (segment),
        .data_out    (data_out),
        .digit_valid (digit_valid),
        .digit_point (digit_point),
        .digit_error (digit_error),
        .frame_done  (frame_done),
        .multi_anode (multi_anode),
        .anode_stuck (anode_stuck)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Drive the pins (just after a falling edge) and watch n clocks, logging frame_done pulses.
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        anode   = an;
        segment = seg;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) begin
                fd_count++;
                fd_prev = fd_last;
                fd_last = cyc;
            end
        end
    endtask

    // One controller frame: 16 clocks per digit slot, disabled slots blank the anodes.
    task automatic scan_frame(input logic [15:0] data, input logic [3:0] en, input logic [3:0] dp);
        for (int i = 0; i < 4; i++) begin
            if (en[i]) hold(~(4'b0001 << i), {~dp[i], hex_seg(data[4*i +: 4])}, 16);
            else       hold(4'hF, 8'hFF, 16);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; anode = 4'hF; segment = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", data_out); end
        checks++; if ({digit_valid, digit_point, digit_error} !== 12'h0) begin errors++;
            $display("FAIL reset_flags: got v=%b p=%b e=%b want all 0", digit_valid, digit_point, digit_error); end
        checks++; if ({frame_done, multi_anode, anode_stuck} !== 3'b000) begin errors++;
            $display("FAIL reset_status: got fd=%b ma=%b st=%b want 000", frame_done, multi_anode, anode_stuck); end
        reset = 1'b0;
    endtask

    task automatic test_full_scan();
        fd_count = 0;
        for (int f = 0; f < 3; f++) scan_frame(16'h1A2F, 4'hF, 4'b0100);
        checks++; if (data_out !== 16'h1A2F) begin errors++; $display("FAIL scan_data: got %h want 1a2f", data_out); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid: got %b want 1111", digit_valid); end
        checks++; if (digit_point !== 4'b0100) begin errors++; $display("FAIL scan_point: got %b want 0100", digit_point); end
        checks++; if (digit_error !== 4'h0 || multi_anode !== 1'b0) begin errors++;
            $display("FAIL scan_errflags: got e=%b ma=%b want 0000 0", digit_error, multi_anode); end
        checks++; if (fd_count != 2) begin errors++; $display("FAIL scan_frames: got %0d want 2", fd_count); end
        checks++; if (fd_last - fd_prev != 64) begin errors++; $display("FAIL scan_period: got %0d want 64", fd_last - fd_prev); end
    endtask

    task automatic test_partial_enable();
        fd_count = 0;
        for (int f = 0; f < 3; f++) scan_frame(16'h5B7C, 4'b0101, 4'b0100);
        checks++; if (digit_valid !== 4'b0101) begin errors++; $display("FAIL part_valid: got %b want 0101", digit_valid); end
        checks++; if (data_out !== 16'h1B2C) begin errors++; $display("FAIL part_data: got %h want 1b2c", data_out); end
        checks++; if (digit_point !== 4'b0100) begin errors++; $display("FAIL part_point: got %b want 0100", digit_point); end
        checks++; if (fd_count != 3) begin errors++; $display("FAIL part_frames: got %0d want 3", fd_count); end
        checks++; if (fd_last - fd_prev != 64) begin errors++; $display("FAIL part_period: got %0d want 64", fd_last - fd_prev); end
    endtask

    task automatic test_bad_pattern();
        fd_count = 0;
        hold(4'b1101, 8'hFF, 4);
        checks++; if (digit_error !== 4'b0000) begin errors++; $display("FAIL bad_early: got %b want 0000", digit_error); end
        hold(4'b1101, 8'hFF, 1);
        checks++; if (digit_error !== 4'b0010) begin errors++; $display("FAIL bad_error: got %b want 0010", digit_error); end
        checks++; if (digit_valid !== 4'b0101 || data_out !== 16'h1B2C) begin errors++;
            $display("FAIL bad_hold: got v=%b d=%h want 0101 1b2c", digit_valid, data_out); end
        hold(4'b1101, 8'hFF, 5);
        hold(4'b1101, 8'h78, 10);
        checks++; if (data_out !== 16'h1B7C) begin errors++; $display("FAIL fix_data: got %h want 1b7c", data_out); end
        checks++; if (digit_valid !== 4'b0111 || digit_error !== 4'b0000) begin errors++;
            $display("FAIL fix_flags: got v=%b e=%b want 0111 0000", digit_valid, digit_error); end
        checks++; if (digit_point !== 4'b0110) begin errors++; $display("FAIL fix_point: got %b want 0110", digit_point); end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL fix_frames: got %0d want 1", fd_count); end
    endtask

    task automatic test_glitch();
        fd_count = 0;
        hold(4'b1110, 8'hC0, 10);
        checks++; if (data_out !== 16'h1B70 || fd_count != 0) begin errors++;
            $display("FAIL glitch_setup: got d=%h fd=%0d want 1b70 0", data_out, fd_count); end
        hold(4'b1110, 8'hF9, 3);
        checks++; if (data_out !== 16'h1B70 || digit_valid !== 4'b0111) begin errors++;
            $display("FAIL glitch_pulse: got d=%h v=%b want 1b70 0111", data_out, digit_valid); end
        hold(4'b1110, 8'hC0, 10);
        checks++; if (data_out !== 16'h1B70) begin errors++; $display("FAIL glitch_after: got %h want 1b70", data_out); end
        checks++; if (digit_valid !== 4'b0011 || fd_count != 1) begin errors++;
            $display("FAIL glitch_frame: got v=%b fd=%0d want 0011 1", digit_valid, fd_count); end
    endtask

    task automatic test_multi_and_stuck();
        fd_count = 0;
        hold(4'b1100, 8'hC0, 10);
        checks++; if (multi_anode !== 1'b1) begin errors++; $display("FAIL multi_set: got %b want 1", multi_anode); end
        checks++; if (data_out !== 16'h1B70 || digit_valid !== 4'b0011 || fd_count != 0) begin errors++;
            $display("FAIL multi_noact: got d=%h v=%b fd=%0d want 1b70 0011 0", data_out, digit_valid, fd_count); end
        scan_frame(16'h1A2F, 4'hF, 4'b0100);
        checks++; if (multi_anode !== 1'b1 || data_out !== 16'h1A2F) begin errors++;
            $display("FAIL multi_sticky: got ma=%b d=%h want 1 1a2f", multi_anode, data_out); end
        hold(4'hF, 8'hFF, 255);
        checks++; if (anode_stuck !== 1'b0) begin errors++; $display("FAIL stuck_early: got %b want 0", anode_stuck); end
        hold(4'hF, 8'hFF, 1);
        checks++; if (anode_stuck !== 1'b1) begin errors++; $display("FAIL stuck_set: got %b want 1", anode_stuck); end
        hold(4'hF, 8'hFF, 20);
        checks++; if (anode_stuck !== 1'b1) begin errors++; $display("FAIL stuck_hold: got %b want 1", anode_stuck); end
        hold(4'b1110, 8'hFF, 1);
        checks++; if (anode_stuck !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b want 0", anode_stuck); end
    endtask

    task automatic test_reset_mid_frame();
        hold(4'b1110, 8'hF9, 16);
        hold(4'b1101, 8'hA4, 16);
        reset = 1'b1; anode = 4'hF; segment = 8'hFF;
        @(negedge clk);
        checks++; if (data_out !== 16'h0 || digit_valid !== 4'h0 || digit_point !== 4'h0 || digit_error !== 4'h0) begin errors++;
            $display("FAIL midrst_digits: got d=%h v=%b p=%b e=%b want all 0", data_out, digit_valid, digit_point, digit_error); end
        checks++; if ({frame_done, multi_anode, anode_stuck} !== 3'b000) begin errors++;
            $display("FAIL midrst_status: got fd=%b ma=%b st=%b want 000", frame_done, multi_anode, anode_stuck); end
        reset = 1'b0;
        fd_count = 0;
        scan_frame(16'h4321, 4'hF, 4'b0000);
        checks++; if (fd_count != 0 || data_out !== 16'h4321) begin errors++;
            $display("FAIL midrst_first: got fd=%0d d=%h want 0 4321", fd_count, data_out); end
        hold(4'b1110, 8'hF9, 16);
        checks++; if (fd_count != 1 || digit_valid !== 4'hF) begin errors++;
            $display("FAIL midrst_close: got fd=%0d v=%b want 1 1111", fd_count, digit_valid); end
    endtask

    initial begin
        reset = 1'b1; anode = 4'hF; segment = 8'hFF;
        @(negedge clk);
        test_reset();
        test_full_scan();
        test_partial_enable();
        test_bad_pattern();
        test_glitch();
        test_multi_and_stuck();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
